// File: rtl/simon_ctrl.sv
// simon_ctrl -- Simon32/64 round sequencer.
//
// Accepts one 32-bit block per start request, steps the external simon_key
// subkey generator through its schedule (forward for encrypt; 28 forward
// pre-advance steps then reverse for decrypt), applies the Simon round
// function using the subkey returned, and presents the result with a
// one-cycle done pulse.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   start     request, sampled only while idle
//   mode      0 = encrypt, 1 = decrypt (latched with start)
//   data_in   block {x, y} (latched with start)
//   subkey    current subkey from simon_key
//   ks_load   simon_key reload (high whenever the key must not advance)
//   ks_dir    simon_key direction (1 = reverse)
//   ks_round  simon_key round counter
//   busy      high while an operation is in flight (PREP/ROUND/DONE)
//   done      one-cycle pulse, data_out valid
//   data_out  result {x, y}, held until the next done
module simon_ctrl #(
  parameter int ROUNDS = 32,
  parameter int PREP   = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] data_in,
  input  logic [15:0] subkey,
  output logic        ks_load,
  output logic        ks_dir,
  output logic [5:0]  ks_round,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PREP  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [5:0] PREP_LAST  = 6'(PREP - 1);
  localparam logic [5:0] ROUND_LAST = 6'(ROUNDS - 1);

  logic [1:0]  state;
  logic [5:0]  ctr;
  logic        mode_q;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] x_next;
  logic [15:0] y_next;
  logic        last_round;

  // Simon round function: (rol1 v & rol8 v) ^ rol2 v
  function automatic logic [15:0] f_round(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  // One Feistel step in either direction; subkey is K_ctr in both cases
  always_comb begin
    x_next = x;
    y_next = y;
    if (mode_q) begin
      y_next = x ^ f_round(y) ^ subkey;
      x_next = y;
    end else begin
      x_next = y ^ f_round(x) ^ subkey;
      y_next = x;
    end
  end

  // Encrypt counts up to ROUNDS-1, decrypt counts down to 0
  assign last_round = mode_q ? (ctr == 6'd0) : (ctr == ROUND_LAST);

  // Control state: sequencing, counter, latched mode, result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ctr      <= 6'd0;
      mode_q   <= 1'b0;
      data_out <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            ctr    <= 6'd0;
            state  <= mode ? S_PREP : S_ROUND;
          end
        end
        S_PREP: begin
          if (ctr == PREP_LAST) begin
            ctr   <= ROUND_LAST;
            state <= S_ROUND;
          end else begin
            ctr <= ctr + 6'd1;
          end
        end
        S_ROUND: begin
          if (last_round) begin
            data_out <= {x_next, y_next};
            state    <= S_DONE;
          end else if (mode_q) begin
            ctr <= ctr - 6'd1;
          end else begin
            ctr <= ctr + 6'd1;
          end
        end
        default: begin
          ctr   <= 6'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Working half-words: loaded on an accepted start, advanced each round
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      x <= data_in[31:16];
      y <= data_in[15:0];
    end else if (state == S_ROUND) begin
      x <= x_next;
      y <= y_next;
    end
  end

  // Key generator holds master key whenever it is not being stepped, so it
  // reloads on the start edge and after each done.
  assign ks_load  = (state == S_IDLE) || (state == S_DONE);
  assign ks_dir   = (state == S_ROUND) && mode_q;
  assign ks_round = (state == S_PREP || state == S_ROUND) ? ctr : 6'd0;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_simon_ctrl.sv
// tb_simon_ctrl -- self-checking bench for simon_ctrl with a behavioural
// simon_key model and an independent software Simon32/64 model.
module tb_simon_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [31:0] data_in;
  logic [15:0] subkey;
  logic        ks_load;
  logic        ks_dir;
  logic [5:0]  ks_round;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [63:0] master_key;

  localparam logic [63:0] Z0  = 64'h19C3522FB386A45F;
  localparam logic [63:0] KAT_KEY = 64'h1918111009080100;

  always #5 clk = ~clk;

  simon_ctrl #(.ROUNDS(32), .PREP(28)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in),
    .subkey(subkey), .ks_load(ks_load), .ks_dir(ks_dir), .ks_round(ks_round),
    .busy(busy), .done(done), .data_out(data_out)
  );

  function automatic logic [15:0] rol(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic zbit(input int i);
    if (i < 0 || i > 61) return 1'b0;
    return Z0[6'(i)];
  endfunction

  function automatic logic [15:0] f_sw(input logic [15:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  function automatic logic [15:0] tmpf(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    t = ror(a, 3) ^ b;
    t = t ^ ror(t, 1);
    return t;
  endfunction

  // Software reference: full key expansion, then 32 rounds
  function automatic logic [31:0] sw_cipher(input logic [63:0] key,
                                            input logic [31:0] blk,
                                            input logic dec);
    logic [15:0] k[32];
    logic [15:0] x, y, t;
    k[0] = key[15:0];  k[1] = key[31:16];
    k[2] = key[47:32]; k[3] = key[63:48];
    for (int i = 4; i < 32; i++)
      k[i] = ~k[i-4] ^ tmpf(k[i-1], k[i-3]) ^ {15'b0, zbit(i - 4)} ^ 16'h3;
    x = blk[31:16];
    y = blk[15:0];
    if (!dec) begin
      for (int i = 0; i < 32; i++) begin
        t = x; x = y ^ f_sw(x) ^ k[i]; y = t;
      end
    end else begin
      for (int i = 31; i >= 0; i--) begin
        t = y; y = x ^ f_sw(y) ^ k[i]; x = t;
      end
    end
    return {x, y};
  endfunction

  // Behavioural simon_key: 4-word window, forward or reverse step per cycle
  logic [15:0] kr[4];
  always_ff @(posedge clk) begin
    if (ks_load) begin
      kr[0] <= master_key[15:0];  kr[1] <= master_key[31:16];
      kr[2] <= master_key[47:32]; kr[3] <= master_key[63:48];
    end else if (!ks_dir) begin
      kr[0] <= kr[1]; kr[1] <= kr[2]; kr[2] <= kr[3];
      kr[3] <= ~kr[0] ^ tmpf(kr[3], kr[1]) ^ {15'b0, zbit(int'(ks_round))} ^ 16'h3;
    end else begin
      kr[3] <= kr[2]; kr[2] <= kr[1]; kr[1] <= kr[0];
      kr[0] <= ~(kr[3] ^ tmpf(kr[2], kr[0]) ^ {15'b0, zbit(int'(ks_round) - 4)} ^ 16'h3);
    end
  end
  assign subkey = ks_dir ? kr[3] : kr[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic m, input logic [31:0] d);
    @(negedge clk);
    start = 1'b1; mode = m; data_in = d;
    exp_q.push_back(sw_cipher(master_key, d, m));
    @(posedge clk); #1;
    start = 1'b0; mode = 1'($urandom); data_in = $urandom;
  endtask

  // Count cycles after the start edge until done; optional control trace
  // (decrypt) and an extra start pulse while busy.
  task automatic wait_done(input int exp_lat, input bit trace, input bit poke,
                           output logic [31:0] got);
    int n;
    bit seen;
    logic [31:0] e;
    n = 0; seen = 0;
    while (n < 100 && !seen) begin
      @(negedge clk); n++;
      if (poke && n == 6) start = 1'b0;
      if (done) seen = 1;
      else begin
        chk("busy_run", busy, 1);
        if (trace) begin
          if (n <= 28) begin
            chk("ks_round_prep", ks_round, n - 1);
            chk("ks_dir_prep", ks_dir, 0);
          end else begin
            chk("ks_round_dec", ks_round, 60 - n);
            chk("ks_dir_dec", ks_dir, 1);
          end
          chk("ks_load_run", ks_load, 0);
        end
        if (poke && n == 5) begin
          start = 1'b1; mode = ~mode; data_in = 32'hDEADBEEF;
        end
      end
    end
    chk("done_latency", n, exp_lat);
    got = data_out;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    chk("data_out", data_out, e);
    chk("busy_in_done", busy, 1);
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("done_single", done, 0);
    chk("busy_fall", busy, 0);
    chk("ks_load_idle", ks_load, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, c, p;
    rst = 1'b1; start = 1'b0; mode = 1'b0; data_in = 32'd0;
    master_key = KAT_KEY;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_ks_load", ks_load, 1);
    chk("rst_ks_dir", ks_dir, 0);
    chk("rst_ks_round", ks_round, 0);
    rst = 1'b0;

    // Encrypt KAT, with a start pulse injected while busy
    pulse_start(1'b0, 32'h65656877);
    wait_done(33, 0, 1, got);
    chk("kat_enc", got, 32'hC69BE9BB);
    after_done();

    // Decrypt KAT with key-schedule control trace
    pulse_start(1'b1, 32'hC69BE9BB);
    wait_done(61, 1, 0, got);
    chk("kat_dec", got, 32'h65656877);
    after_done();

    // Back-to-back: encrypt, then decrypt started the cycle after done
    pulse_start(1'b0, 32'h65656877);
    wait_done(33, 0, 0, got);
    chk("b2b_enc", got, 32'hC69BE9BB);
    start = 1'b1; mode = 1'b0; data_in = 32'h0BADF00D;  // in DONE: ignored
    @(negedge clk);
    chk("b2b_gap_busy", busy, 0);
    chk("b2b_gap_done", done, 0);
    mode = 1'b1; data_in = 32'hC69BE9BB;
    exp_q.push_back(32'h65656877);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy_rise", busy, 1);
    wait_done(61, 0, 0, got);
    chk("b2b_dec", got, 32'h65656877);
    chk("b2b_hold", data_out, 32'h65656877);
    after_done();

    // Reset during round 10 of an encrypt
    pulse_start(1'b0, 32'h65656877);
    repeat (11) @(negedge clk);
    chk("mid_round_ctr", ks_round, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_data_out", data_out, 32'd0);
    chk("mid_rst_ks_load", ks_load, 1);
    chk("mid_rst_ks_dir", ks_dir, 0);
    chk("mid_rst_ks_round", ks_round, 0);
    pulse_start(1'b0, 32'h65656877);
    wait_done(33, 0, 0, got);
    chk("post_rst_enc", got, 32'hC69BE9BB);
    after_done();

    // Random key/block round trips
    for (int i = 0; i < 200; i++) begin
      master_key = {$urandom, $urandom};
      p = $urandom;
      pulse_start(1'b0, p);
      wait_done(33, 0, 0, c);
      after_done();
      pulse_start(1'b1, c);
      wait_done(61, 0, 0, got);
      chk("rand_roundtrip", got, p);
      after_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
